// File: rtl/psram_mux_ctrl_if.sv
// -----------------------------------------------------------------------------
// psram_mux_ctrl_if
// Requester-side bundle of the PSRAM access controller.
//   ch_req   : per-channel request, held until ack      (master -> slave)
//   ch_we    : per-channel write flag, 1 = write        (master -> slave)
//   ch_addr  : per-channel byte address, NCH*ADDR_W     (master -> slave)
//   ch_wdata : per-channel write byte, NCH*8            (master -> slave)
//   ch_rdata : per-channel read byte, NCH*8             (slave -> master)
//   ch_ack   : per-channel one-cycle completion pulse   (slave -> master)
//   busy     : controller is not idle                   (slave -> master)
// -----------------------------------------------------------------------------
interface psram_mux_ctrl_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 23
);
    logic [NCH-1:0]        ch_req;
    logic [NCH-1:0]        ch_we;
    logic [NCH*ADDR_W-1:0] ch_addr;
    logic [NCH*8-1:0]      ch_wdata;
    logic [NCH*8-1:0]      ch_rdata;
    logic [NCH-1:0]        ch_ack;
    logic                  busy;

    modport master (
        output ch_req, ch_we, ch_addr, ch_wdata,
        input  ch_rdata, ch_ack, busy
    );

    modport slave (
        input  ch_req, ch_we, ch_addr, ch_wdata,
        output ch_rdata, ch_ack, busy
    );
endinterface

// File: rtl/psram_mux_ctrl.sv
// -----------------------------------------------------------------------------
// psram_mux_ctrl
// Registered arbiter/controller placing NCH byte-wide requesters onto a single
// 16-bit asynchronous PSRAM with programmable access and recovery timing.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave modport) : per-channel req/we/addr/wdata in, rdata/ack/busy out
//   ram_a               : PSRAM word address (byte address >> 1)
//   ram_dq_i            : PSRAM read data
//   ram_dq_o, ram_dq_oe : PSRAM write data (byte on both lanes) and its enable
//   ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n : PSRAM strobes
// Every pin is driven straight from a flop.
// -----------------------------------------------------------------------------
module psram_mux_ctrl #(
    parameter int NCH        = 2,
    parameter int ADDR_W     = 23,
    parameter int ACC_CYCLES = 4,
    parameter int REC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    psram_mux_ctrl_if.slave   bus,
    output logic [ADDR_W-2:0] ram_a,
    input  logic [15:0]       ram_dq_i,
    output logic [15:0]       ram_dq_o,
    output logic              ram_dq_oe,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              ram_lb_n,
    output logic              ram_ub_n
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int MAX_C = (ACC_CYCLES > REC_CYCLES) ? ACC_CYCLES : REC_CYCLES;
    localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [IDX_W-1:0]    rr_r;
    logic [IDX_W-1:0]    gnt_r;
    logic                we_r;
    logic                lane_r;
    logic [ADDR_W-2:0]   ram_a_r;
    logic [15:0]         dq_o_r;
    logic                dq_oe_r;
    logic                ce_n_r;
    logic                oe_n_r;
    logic                we_n_r;
    logic                lb_n_r;
    logic                ub_n_r;
    logic [NCH-1:0]      ack_r;
    logic [NCH*8-1:0]    rdata_r;
    logic                busy_r;

    logic [NCH-1:0]      elig_s;
    logic                gnt_found_s;
    logic [IDX_W-1:0]    gnt_idx_s;
    logic [IDX_W-1:0]    cand_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic                sel_we_s;
    logic [7:0]          sel_wdata_s;

    // A channel is masked during its own ack cycle so a req held one cycle
    // past ack is not served twice.
    assign elig_s = bus.ch_req & ~ack_r;

    // Round-robin pick: first eligible channel after the last grant, wrapping.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        cand_s      = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand_s = IDX_W'((int'(rr_r) + k) % NCH);
            if (!gnt_found_s && elig_s[cand_s]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = cand_s;
            end else begin
                gnt_idx_s   = gnt_idx_s;
            end
        end
    end

    assign sel_addr_s  = bus.ch_addr[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
    assign sel_we_s    = bus.ch_we[gnt_idx_s];
    assign sel_wdata_s = bus.ch_wdata[int'(gnt_idx_s)*8 +: 8];

    // Access FSM with all pin and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            rr_r    <= IDX_W'(NCH - 1);
            gnt_r   <= '0;
            we_r    <= 1'b0;
            lane_r  <= 1'b0;
            ram_a_r <= '0;
            dq_o_r  <= 16'h0000;
            dq_oe_r <= 1'b0;
            ce_n_r  <= 1'b1;
            oe_n_r  <= 1'b1;
            we_n_r  <= 1'b1;
            lb_n_r  <= 1'b1;
            ub_n_r  <= 1'b1;
            ack_r   <= '0;
            rdata_r <= '0;
            busy_r  <= 1'b0;
        end else begin
            ack_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (gnt_found_s) begin
                        state_r <= ST_ACCESS;
                        busy_r  <= 1'b1;
                        cnt_r   <= CNT_W'(ACC_CYCLES - 1);
                        rr_r    <= gnt_idx_s;
                        gnt_r   <= gnt_idx_s;
                        we_r    <= sel_we_s;
                        lane_r  <= sel_addr_s[0];
                        ram_a_r <= sel_addr_s[ADDR_W-1:1];
                        ce_n_r  <= 1'b0;
                        lb_n_r  <= sel_addr_s[0];
                        ub_n_r  <= ~sel_addr_s[0];
                        if (sel_we_s) begin
                            we_n_r  <= 1'b0;
                            oe_n_r  <= 1'b1;
                            dq_oe_r <= 1'b1;
                            dq_o_r  <= {sel_wdata_s, sel_wdata_s};
                        end else begin
                            we_n_r  <= 1'b1;
                            oe_n_r  <= 1'b0;
                            dq_oe_r <= 1'b0;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_r == '0) begin
                        ce_n_r       <= 1'b1;
                        oe_n_r       <= 1'b1;
                        we_n_r       <= 1'b1;
                        lb_n_r       <= 1'b1;
                        ub_n_r       <= 1'b1;
                        dq_oe_r      <= 1'b0;
                        ack_r[gnt_r] <= 1'b1;
                        if (!we_r) begin
                            rdata_r[int'(gnt_r)*8 +: 8] <= lane_r ? ram_dq_i[15:8] : ram_dq_i[7:0];
                        end else begin
                            rdata_r <= rdata_r;
                        end
                        if (REC_CYCLES > 0) begin
                            state_r <= ST_RECOVER;
                            cnt_r   <= CNT_W'(REC_CYCLES - 1);
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                ST_RECOVER: begin
                    if (cnt_r == '0) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    ce_n_r  <= 1'b1;
                    oe_n_r  <= 1'b1;
                    we_n_r  <= 1'b1;
                    lb_n_r  <= 1'b1;
                    ub_n_r  <= 1'b1;
                    dq_oe_r <= 1'b0;
                end
            endcase
        end
    end

    assign ram_a        = ram_a_r;
    assign ram_dq_o     = dq_o_r;
    assign ram_dq_oe    = dq_oe_r;
    assign ram_ce_n     = ce_n_r;
    assign ram_oe_n     = oe_n_r;
    assign ram_we_n     = we_n_r;
    assign ram_lb_n     = lb_n_r;
    assign ram_ub_n     = ub_n_r;
    assign bus.ch_ack   = ack_r;
    assign bus.ch_rdata = rdata_r;
    assign bus.busy     = busy_r;

endmodule
